// File: rtl/mem_arbiter.sv
// Arbiter serialising the CPU's DM then IM access onto one fixed-latency single-port memory.
// Optional one-entry instruction buffer compiled in with `define MEM_ARB_IBUF_EN.
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IM_enable,
  input  logic [31:0] IM_address,
  output logic [31:0] IM_out,
  input  logic        DM_enable,
  input  logic        DM_write,
  input  logic [31:0] DM_address,
  input  logic [31:0] DM_in,
  output logic [31:0] DM_out,
  output logic        stall,
  output logic        MEM_enable,
  output logic        MEM_write,
  output logic [31:0] MEM_address,
  output logic [31:0] MEM_in,
  input  logic [31:0] MEM_out
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, DM_ACC, IM_ACC, RELEASE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        acc_first, acc_last;
  logic        im_hit, im_hit_dm, hit_take;
  logic [31:0] hit_data;

  // cnt loads MEM_LAT on entry, so the strobe cycle is cnt == MEM_LAT and capture is cnt == 0
  assign acc_first = (cnt == LAT);
  assign acc_last  = (cnt == 4'd0);

`ifdef MEM_ARB_IBUF_EN
  logic        ibuf_valid;
  logic [31:0] ibuf_tag;
  logic [31:0] ibuf_data;
  logic        store_kill;

  assign store_kill = DM_write && (DM_address == ibuf_tag);
  assign im_hit     = ibuf_valid && (ibuf_tag == IM_address);
  // a store to the buffered address in the same CPU cycle turns the fetch into a miss
  assign im_hit_dm  = im_hit && !store_kill;
  assign hit_data   = ibuf_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf_valid <= 1'b0;
    end else if (state == IM_ACC && acc_last) begin
      ibuf_valid <= 1'b1;
    end else if (state == DM_ACC && acc_last && store_kill) begin
      ibuf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IM_ACC && acc_last) begin
      ibuf_tag  <= IM_address;
      ibuf_data <= MEM_out;
    end
  end
`else
  assign im_hit    = 1'b0;
  assign im_hit_dm = 1'b0;
  assign hit_data  = 32'd0;
`endif

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    MEM_enable  = 1'b0;
    MEM_write   = 1'b0;
    MEM_address = 32'd0;
    MEM_in      = 32'd0;
    hit_take    = 1'b0;
    case (state)
      IDLE: begin
        stall = IM_enable | DM_enable;
        if (DM_enable) begin
          state_nxt = DM_ACC;
        end else if (IM_enable) begin
          if (im_hit) begin
            state_nxt = RELEASE;
            hit_take  = 1'b1;
          end else begin
            state_nxt = IM_ACC;
          end
        end
      end
      DM_ACC: begin
        stall       = 1'b1;
        MEM_enable  = acc_first;
        MEM_write   = DM_write;
        MEM_address = DM_address;
        MEM_in      = DM_in;
        if (acc_last) begin
          if (IM_enable && im_hit_dm) begin
            state_nxt = RELEASE;
            hit_take  = 1'b1;
          end else if (IM_enable) begin
            state_nxt = IM_ACC;
          end else begin
            state_nxt = RELEASE;
          end
        end
      end
      IM_ACC: begin
        stall       = 1'b1;
        MEM_enable  = acc_first;
        MEM_address = IM_address;
        if (acc_last) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == DM_ACC || state_nxt == IM_ACC) && state_nxt != state) begin
        cnt <= LAT;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // reset wins over a capture, so an in-flight result is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      IM_out <= 32'd0;
      DM_out <= 32'd0;
    end else begin
      if (state == DM_ACC && acc_last && !DM_write) begin
        DM_out <= MEM_out;
      end
      if (state == IM_ACC && acc_last) begin
        IM_out <= MEM_out;
      end else if (hit_take) begin
        IM_out <= hit_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 has MEM_LAT=1, instance 1 has MEM_LAT=2,
// each with its own fixed-latency memory model.
module tb_mem_arbiter;

`ifdef MEM_ARB_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       im_en, dm_en, dm_wr;
  logic [1:0][31:0] im_addr, dm_addr, dm_in;
  logic [1:0][31:0] im_out, dm_out, mem_addr, mem_in, mem_out;
  logic [1:0]       stall, mem_en, mem_wr;

  int n_tests = 0;
  int n_fail  = 0;

  int          n_stall, n_stb, gap;
  logic [31:0] a0, a1, din0;
  logic        w0;

  mem_arbiter #(.MEM_LAT(1)) u_arb0 (
    .clk(clk), .rst(rst),
    .IM_enable(im_en[0]), .IM_address(im_addr[0]), .IM_out(im_out[0]),
    .DM_enable(dm_en[0]), .DM_write(dm_wr[0]), .DM_address(dm_addr[0]),
    .DM_in(dm_in[0]), .DM_out(dm_out[0]), .stall(stall[0]),
    .MEM_enable(mem_en[0]), .MEM_write(mem_wr[0]), .MEM_address(mem_addr[0]),
    .MEM_in(mem_in[0]), .MEM_out(mem_out[0])
  );

  mem_arbiter #(.MEM_LAT(2)) u_arb1 (
    .clk(clk), .rst(rst),
    .IM_enable(im_en[1]), .IM_address(im_addr[1]), .IM_out(im_out[1]),
    .DM_enable(dm_en[1]), .DM_write(dm_wr[1]), .DM_address(dm_addr[1]),
    .DM_in(dm_in[1]), .DM_out(dm_out[1]), .stall(stall[1]),
    .MEM_enable(mem_en[1]), .MEM_write(mem_wr[1]), .MEM_address(mem_addr[1]),
    .MEM_in(mem_in[1]), .MEM_out(mem_out[1])
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0100: rom = 32'h0050_0093;
      32'h0000_0104: rom = 32'h00A0_0113;
      32'h0000_2000: rom = 32'hDEAD_BEEF;
      32'h0000_3000: rom = 32'h0000_0011;
      default:       rom = {a[15:0], 16'hA5A5};
    endcase
  endfunction

  // memory models: data is only valid in the cycle MEM_LAT after the strobe cycle
  int          age0 = 0, age1 = 0;
  logic [31:0] rd0, rd1, pa0, pa1, pd0, pd1;
  logic        pv0 = 1'b0, pv1 = 1'b0;

  always @(posedge clk) begin
    if (mem_en[0]) begin
      age0 <= 1;
      rd0  <= (pv0 && pa0 == mem_addr[0]) ? pd0 : rom(mem_addr[0]);
      if (mem_wr[0]) begin
        pv0 <= 1'b1;
        pa0 <= mem_addr[0];
        pd0 <= mem_in[0];
      end
    end else if (age0 != 0 && age0 < 20) begin
      age0 <= age0 + 1;
    end
  end

  always @(posedge clk) begin
    if (mem_en[1]) begin
      age1 <= 1;
      rd1  <= (pv1 && pa1 == mem_addr[1]) ? pd1 : rom(mem_addr[1]);
      if (mem_wr[1]) begin
        pv1 <= 1'b1;
        pa1 <= mem_addr[1];
        pd1 <= mem_in[1];
      end
    end else if (age1 != 0 && age1 < 20) begin
      age1 <= age1 + 1;
    end
  end

  assign mem_out[0] = (age0 == 1) ? rd0 : 32'hBAAD_F00D;
  assign mem_out[1] = (age1 == 2) ? rd1 : 32'hBAAD_F00D;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // samples one transaction until the RELEASE cycle; returns at the RELEASE negedge
  task automatic run_txn(input int d);
    int  first;
    bit  done;
    n_stall = 0; n_stb = 0; gap = 0; a0 = 0; a1 = 0; w0 = 0; din0 = 0;
    first = 0; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (mem_en[d]) begin
        if (n_stb == 0) begin
          a0 = mem_addr[d]; w0 = mem_wr[d]; din0 = mem_in[d]; first = cyc;
        end else begin
          a1 = mem_addr[d]; gap = cyc - first;
        end
        n_stb++;
      end
      if (stall[d]) n_stall++;
      else done = 1'b1;
    end
    check_eq("txn_released", 32'(done), 32'd1);
  endtask

  task automatic req(input int d, input logic dm, input logic wr, input logic [31:0] daddr,
                     input logic [31:0] ddata, input logic im, input logic [31:0] iaddr);
    tick();
    dm_en[d] = dm; dm_wr[d] = wr; dm_addr[d] = daddr; dm_in[d] = ddata;
    im_en[d] = im; im_addr[d] = iaddr;
    run_txn(d);
  endtask

  task automatic drop(input int d);
    tick();
    dm_en[d] = 1'b0; dm_wr[d] = 1'b0; im_en[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    im_en = '0; dm_en = '0; dm_wr = '0;
    im_addr = '0; dm_addr = '0; dm_in = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_im_out", im_out[d], 32'd0);
      check_eq("rst_dm_out", dm_out[d], 32'd0);
      check_eq("rst_mem_en", 32'(mem_en[d]), 32'd0);
      check_eq("rst_stall", 32'(stall[d]), 32'd0);
      check_eq("rst_mem_addr", mem_addr[d], 32'd0);
    end
    im_en[0] = 1'b1;
    @(negedge clk);
    check_eq("rst_stall_follows_req", 32'(stall[0]), 32'd1);
    check_eq("rst_no_strobe", 32'(mem_en[0]), 32'd0);
    im_en[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // LAT=1 IM-only fetch
    req(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
    check_eq("if_stall", 32'(n_stall), 32'd3);
    check_eq("if_strobes", 32'(n_stb), 32'd1);
    check_eq("if_addr", a0, 32'h100);
    check_eq("if_im_out", im_out[0], 32'h0050_0093);
    drop(0);

    // LAT=2 DM load plus IM fetch
    req(1, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 32'h104);
    check_eq("dmim_stall", 32'(n_stall), 32'd7);
    check_eq("dmim_strobes", 32'(n_stb), 32'd2);
    check_eq("dmim_addr0", a0, 32'h2000);
    check_eq("dmim_addr1", a1, 32'h104);
    check_eq("dmim_gap", 32'(gap), 32'd3);
    check_eq("dmim_dm_out", dm_out[1], 32'hDEAD_BEEF);
    check_eq("dmim_im_out", im_out[1], 32'h00A0_0113);
    drop(1);

    // load 0x11, then a store must leave DM_out alone
    req(0, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 32'h0);
    check_eq("ld_stall", 32'(n_stall), 32'd3);
    check_eq("ld_dm_out", dm_out[0], 32'h11);
    drop(0);
    req(0, 1'b1, 1'b1, 32'h2004, 32'h55AA_55AA, 1'b0, 32'h0);
    check_eq("st_strobes", 32'(n_stb), 32'd1);
    check_eq("st_write", 32'(w0), 32'd1);
    check_eq("st_addr", a0, 32'h2004);
    check_eq("st_data", din0, 32'h55AA_55AA);
    check_eq("st_dm_out", dm_out[0], 32'h11);
    check_eq("st_im_out", im_out[0], 32'h0050_0093);
    drop(0);

    // reset in the second DM_ACC cycle of the LAT=2 instance
    tick();
    dm_en[1] = 1'b1; dm_wr[1] = 1'b0; dm_addr[1] = 32'h3000;
    tick();
    @(negedge clk);
    check_eq("rmid_strobe", 32'(mem_en[1]), 32'd1);
    tick();
    rst = 1'b1; dm_en[1] = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rmid_stall", 32'(stall[1]), 32'd0);
    check_eq("rmid_mem_en", 32'(mem_en[1]), 32'd0);
    check_eq("rmid_dm_out", dm_out[1], 32'd0);
    repeat (3) @(negedge clk);
    check_eq("rmid_no_late_capture", dm_out[1], 32'd0);
    check_eq("idle_stall", 32'(stall[1]), 32'd0);

    // instruction buffer sequence on the LAT=1 instance
    req(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
    check_eq("ib1_stall", 32'(n_stall), 32'd3);
    check_eq("ib1_strobes", 32'(n_stb), 32'd1);
    check_eq("ib1_im_out", im_out[0], 32'h0050_0093);
    drop(0);
    req(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
    check_eq("ib2_stall", 32'(n_stall), IBUF ? 32'd1 : 32'd3);
    check_eq("ib2_strobes", 32'(n_stb), IBUF ? 32'd0 : 32'd1);
    check_eq("ib2_im_out", im_out[0], 32'h0050_0093);
    drop(0);
    req(0, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b1, 32'h100);
    check_eq("ib3_stall", 32'(n_stall), IBUF ? 32'd3 : 32'd5);
    check_eq("ib3_strobes", 32'(n_stb), IBUF ? 32'd1 : 32'd2);
    check_eq("ib3_dm_out", dm_out[0], 32'h11);
    check_eq("ib3_im_out", im_out[0], 32'h0050_0093);
    drop(0);
    req(0, 1'b1, 1'b1, 32'h100, 32'hCAFE_0001, 1'b1, 32'h100);
    check_eq("ib4_stall", 32'(n_stall), 32'd5);
    check_eq("ib4_strobes", 32'(n_stb), 32'd2);
    check_eq("ib4_fetch_addr", a1, 32'h100);
    check_eq("ib4_im_out", im_out[0], 32'hCAFE_0001);
    check_eq("ib4_dm_out", dm_out[0], 32'h11);
    drop(0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
